// File: rtl/joy_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : joy_serializer
//  Purpose  : Target-side emulator of the two-player serial joystick chain.
//             Captures two 8-bit pads (or their alternate banks) on the
//             reader's load strobe and shifts them out, active-low, one bit
//             per rising edge of the reader's shift clock.
//  Revision : 1.0 - initial release
// ============================================================================
module joy_serializer #(
  parameter int SYNC  = 2,   // synchroniser depth on joyCk/joyLd/joyS (>= 2)
  parameter int FRAME = 16   // two 8-bit pads; not meant to be overridden
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       joyCk,
  input  logic       joyLd,
  input  logic       joyS,
  output logic       joyD,
  input  logic [7:0] joy1,
  input  logic [7:0] joy2,
  input  logic [7:0] joy1x,
  input  logic [7:0] joy2x,
  output logic       loaded,
  output logic       done,
  output logic       overrun
);

  localparam int             CW      = $clog2(FRAME + 1);
  localparam logic [CW-1:0]  CNT_END = CW'(FRAME);

  // Synchroniser chains plus one delay flop each for the edge detectors
  logic [SYNC-1:0] ck_sync;
  logic [SYNC-1:0] ld_sync;
  logic [SYNC-1:0] s_sync;
  logic            ck_d;
  logic            ld_d;

  logic            ck_s;
  logic            ld_s;
  logic            s_s;
  logic            ck_rise;
  logic            ld_fall;

  // Frame state
  logic [FRAME-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [FRAME-1:0] sr_next;
  logic [CW-1:0]    cnt_next;
  logic             done_evt;
  logic             ovr_evt;

  assign ck_s    = ck_sync[SYNC-1];
  assign ld_s    = ld_sync[SYNC-1];
  assign s_s     = s_sync[SYNC-1];
  assign ck_rise = ck_s & ~ck_d;
  assign ld_fall = ~ld_s & ld_d;

  // Bring the reader's asynchronous strobes into the clock domain. The
  // reset values match the idle bus levels so no edge fires on release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_sync <= '1;
      ld_sync <= '1;
      s_sync  <= '0;
      ck_d    <= 1'b1;
      ld_d    <= 1'b1;
    end else begin
      ck_sync <= {ck_sync[SYNC-2:0], joyCk};
      ld_sync <= {ld_sync[SYNC-2:0], joyLd};
      s_sync  <= {s_sync[SYNC-2:0], joyS};
      ck_d    <= ck_s;
      ld_d    <= ld_s;
    end
  end

  // Next-state of the shifter: load is a level and beats any shift edge.
  always_comb begin
    sr_next  = sr;
    cnt_next = cnt;
    done_evt = 1'b0;
    ovr_evt  = 1'b0;
    if (!ld_s) begin
      sr_next  = s_s ? {joy2, joy1} : {joy2x, joy1x};
      cnt_next = '0;
    end else if (ck_rise) begin
      if (cnt != CNT_END) begin
        sr_next  = {1'b0, sr[FRAME-1:1]};
        cnt_next = cnt + 1'b1;
        done_evt = (cnt == CNT_END - 1'b1);
      end else begin
        ovr_evt  = 1'b1;
      end
    end
  end

  // Register the frame state and all outputs. joyD is derived from the
  // next state so each bit appears together with the shift that exposes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      cnt     <= CNT_END;
      joyD    <= 1'b1;
      loaded  <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sr      <= sr_next;
      cnt     <= cnt_next;
      joyD    <= (cnt_next == CNT_END) ? 1'b1 : ~sr_next[0];
      loaded  <= ld_fall;
      done    <= done_evt;
      if (ld_fall) begin
        overrun <= 1'b0;
      end else if (ovr_evt) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
